sd_sector_buffer: RTL and testbench

- Sits directly downstream of the SD card SPI front end (sector/read request in, byte stream out).
- Accepts one sector read request from the emulated disk controller and issues it to the SD front end.
- Collects the 512 returned bytes into a 256x16 word buffer, then signals completion.
- The controller then reads words at random, with one-cycle latency.

---
 rtl/sd_sector_buffer_if.sv | 30 +++
 rtl/sd_sector_buffer.sv | 168 ++++++++++++++++
 tb/tb_sd_sector_buffer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_buffer_if.sv
// Bundled controller-side and SD-front-end-side signals of sd_sector_buffer.
// master = controller plus SD front end (drives requests, bytes and flags); slave = the buffer.
interface sd_sector_buffer_if;
  // req is a one-cycle strobe that is taken only while busy=0; done/err are one-cycle
  // completion pulses that end busy. sd_valid/sd_rdone/sd_init come from the slow SD side
  // and are treated as levels whose rising (or, for sd_init, falling) edge carries meaning.
  logic        req;
  logic [31:0] lba;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic        sd_init;
  logic [31:0] sd_sec;
  logic        sd_read;
  logic        sd_rdone;
  logic [7:0]  sd_data;
  logic        sd_valid;

  modport master (
    output req, lba, rd_addr, sd_init, sd_rdone, sd_data, sd_valid,
    input  busy, done, err, rd_data, sd_sec, sd_read
  );

  modport slave (
    input  req, lba, rd_addr, sd_init, sd_rdone, sd_data, sd_valid,
    output busy, done, err, rd_data, sd_sec, sd_read
  );
endinterface

// File: rtl/sd_sector_buffer.sv
// Single-sector read buffer between the emulated disk controller and the SD SPI front end.
// Optional read watchdog is enabled by defining SECBUF_TIMEOUT_EN.
module sd_sector_buffer #(
  parameter logic [31:0] BASE_LBA       = 32'd0,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_500_000
) (
  input  logic                clk_25MHz,
  input  logic                rst,
  sd_sector_buffer_if.slave   bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_WAIT_INIT = 2'd0,
    S_IDLE      = 2'd1,
    S_ISSUE     = 2'd2,
    S_FILL      = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_sd_read;
  logic [31:0] r_sd_sec;
  logic [15:0] r_rd_data;
  logic [9:0]  r_count;

  // Two-flop copies plus one extra stage for edge detection on the copies.
  logic        r_valid_s1, r_valid_s2, r_valid_s3;
  logic        r_rdone_s1, r_rdone_s2, r_rdone_s3;
  logic        r_init_s1,  r_init_s2,  r_init_s3;
  logic [7:0]  r_data_s1,  r_data_s2;

  logic [7:0]  r_mem_lo [0:255];
  logic [7:0]  r_mem_hi [0:255];

  logic        w_valid_rise;
  logic        w_rdone_rise;
  logic        w_init_fall;
  logic        w_in_flight;
  logic        w_we;
  logic [9:0]  w_count_nx;
  logic        w_tmo_hit;

  assign w_valid_rise = r_valid_s2 & ~r_valid_s3;
  assign w_rdone_rise = r_rdone_s2 & ~r_rdone_s3;
  assign w_init_fall  = ~r_init_s2 & r_init_s3;
  assign w_in_flight  = (r_state == S_ISSUE) || (r_state == S_FILL);

  // Bytes past 512 are dropped and the counter holds at 512.
  assign w_we = ~rst & w_valid_rise &
                ((r_state == S_ISSUE) || ((r_state == S_FILL) && (r_count != 10'd512)));
  assign w_count_nx = r_count + {9'd0, w_we};

`ifdef SECBUF_TIMEOUT_EN
  logic [23:0] r_tmo;
  assign w_tmo_hit = (r_tmo == (TIMEOUT_CYCLES - 24'd1)) & ~w_we;

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      r_tmo <= 24'd0;
    end else if ((r_state == S_IDLE) || w_we) begin
      r_tmo <= 24'd0;
    end else if (w_in_flight) begin
      r_tmo <= r_tmo + 24'd1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_tmo_hit    = 1'b0;
`endif

  // Buffer array carries no reset; a same-cycle read sees the pre-write word.
  always_ff @(posedge clk_25MHz) begin
    if (w_we) begin
      if (r_count[0]) r_mem_hi[r_count[8:1]] <= r_data_s2;
      else            r_mem_lo[r_count[8:1]] <= r_data_s2;
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      r_state    <= S_WAIT_INIT;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_sd_read  <= 1'b0;
      r_sd_sec   <= 32'd0;
      r_rd_data  <= 16'd0;
      r_count    <= 10'd0;
      r_valid_s1 <= 1'b0; r_valid_s2 <= 1'b0; r_valid_s3 <= 1'b0;
      r_rdone_s1 <= 1'b0; r_rdone_s2 <= 1'b0; r_rdone_s3 <= 1'b0;
      r_init_s1  <= 1'b0; r_init_s2  <= 1'b0; r_init_s3  <= 1'b0;
      r_data_s1  <= 8'd0; r_data_s2  <= 8'd0;
    end else begin
      r_valid_s1 <= bus.sd_valid; r_valid_s2 <= r_valid_s1; r_valid_s3 <= r_valid_s2;
      r_rdone_s1 <= bus.sd_rdone; r_rdone_s2 <= r_rdone_s1; r_rdone_s3 <= r_rdone_s2;
      r_init_s1  <= bus.sd_init;  r_init_s2  <= r_init_s1;  r_init_s3  <= r_init_s2;
      r_data_s1  <= bus.sd_data;  r_data_s2  <= r_data_s1;
      r_rd_data  <= {r_mem_hi[bus.rd_addr], r_mem_lo[bus.rd_addr]};
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      if (w_we) r_count <= w_count_nx;

      if (w_init_fall && (r_state != S_WAIT_INIT)) begin
        r_sd_read <= 1'b0;
        r_busy    <= 1'b1;
        r_err     <= w_in_flight;
        r_state   <= S_WAIT_INIT;
      end else begin
        case (r_state)
          S_WAIT_INIT: begin
            if (r_init_s2) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          S_IDLE: begin
            if (bus.req) begin
              r_sd_sec  <= bus.lba + BASE_LBA;
              r_count   <= 10'd0;
              r_sd_read <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            // sd_read is held until data flows, in case the front end still runs on its slow init clock.
            if (w_valid_rise) begin
              r_sd_read <= 1'b0;
              r_state   <= S_FILL;
            end else if (w_tmo_hit) begin
              r_sd_read <= 1'b0;
              r_err     <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end
          end
          S_FILL: begin
            if (w_rdone_rise) begin
              r_done  <= (w_count_nx == 10'd512);
              r_err   <= (w_count_nx != 10'd512);
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else if (w_tmo_hit) begin
              r_sd_read <= 1'b0;
              r_err     <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end
          end
          default: r_state <= S_WAIT_INIT;
        endcase
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.sd_read = r_sd_read;
  assign bus.sd_sec  = r_sd_sec;
  assign bus.rd_data = r_rd_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Directed bench for sd_sector_buffer with BASE_LBA=100 and a 1000-cycle watchdog limit.
module tb_sd_sector_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  sd_sector_buffer_if bus();
  logic [1:0] dbg_state;

  sd_sector_buffer #(
    .BASE_LBA       (32'd100),
    .TIMEOUT_CYCLES (24'd1000)
  ) dut (
    .clk_25MHz   (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int done_seen = 0;
  int err_seen  = 0;
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.done) done_seen++;
    if (bus.err)  err_seen++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_req(input logic [31:0] l);
    @(negedge clk);
    bus.req = 1'b1;
    bus.lba = l;
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    bus.sd_data  = b;
    bus.sd_valid = 1'b1;
    tick(hi);
    bus.sd_valid = 1'b0;
    tick(lo);
  endtask

  task automatic pulse_rdone();
    bus.sd_rdone = 1'b1;
    tick(2);
    bus.sd_rdone = 1'b0;
    tick(6);
  endtask

  task automatic read_word(input logic [7:0] a, output logic [15:0] d);
    bus.rd_addr = a;
    tick(1);
    d = bus.rd_data;
  endtask

  task automatic wait_idle(output int lat);
    lat = 0;
    while (bus.busy && lat < 20) begin
      tick(1);
      lat++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_cmp++; if (bus.busy !== 1'b1)     begin n_mis++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0)     begin n_mis++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.err !== 1'b0)      begin n_mis++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.sd_read !== 1'b0)  begin n_mis++; $display("FAIL reset_sd_read: got %b want 0", bus.sd_read); end
    n_cmp++; if (bus.sd_sec !== 32'd0)  begin n_mis++; $display("FAIL reset_sd_sec: got %0d want 0", bus.sd_sec); end
    n_cmp++; if (bus.rd_data !== 16'd0) begin n_mis++; $display("FAIL reset_rd_data: got %h want 0000", bus.rd_data); end
    n_cmp++; if (dbg_state !== 2'd0)    begin n_mis++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_init_gating();
    int lat;
    do_req(32'd5);
    tick(4);
    n_cmp++; if (bus.busy !== 1'b1)    begin n_mis++; $display("FAIL gate_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.sd_read !== 1'b0) begin n_mis++; $display("FAIL gate_sd_read: got %b want 0", bus.sd_read); end
    bus.sd_init = 1'b1;
    wait_idle(lat);
    n_cmp++; if (bus.busy !== 1'b0 || lat > 3) begin n_mis++; $display("FAIL gate_release: busy %b after %0d cycles, want 0 within 3", bus.busy, lat); end
    n_cmp++; if (dbg_state !== 2'd1)   begin n_mis++; $display("FAIL gate_state: got %0d want 1", dbg_state); end
  endtask

  task automatic test_nominal();
    int d0, e0;
    logic [15:0] got;
    logic [7:0] addrs [4];
    addrs[0] = 8'd0; addrs[1] = 8'd255; addrs[2] = 8'd128; addrs[3] = 8'd10;
    d0 = done_seen; e0 = err_seen;
    do_req(32'd7);
    n_cmp++; if (bus.sd_sec !== 32'd107) begin n_mis++; $display("FAIL nom_sd_sec: got %0d want 107", bus.sd_sec); end
    n_cmp++; if (bus.sd_read !== 1'b1)   begin n_mis++; $display("FAIL nom_sd_read_hi: got %b want 1", bus.sd_read); end
    n_cmp++; if (bus.busy !== 1'b1)      begin n_mis++; $display("FAIL nom_busy: got %b want 1", bus.busy); end
    send_byte(8'h00, 2, 14);
    n_cmp++; if (bus.sd_read !== 1'b0)   begin n_mis++; $display("FAIL nom_sd_read_lo: got %b want 0", bus.sd_read); end
    for (int i = 1; i < 512; i++) send_byte(8'(i), 2, 14);
    pulse_rdone();
    n_cmp++; if (done_seen - d0 !== 1) begin n_mis++; $display("FAIL nom_done_cnt: got %0d want 1", done_seen - d0); end
    n_cmp++; if (err_seen - e0 !== 0)  begin n_mis++; $display("FAIL nom_err_cnt: got %0d want 0", err_seen - e0); end
    n_cmp++; if (bus.busy !== 1'b0)    begin n_mis++; $display("FAIL nom_busy_end: got %b want 0", bus.busy); end
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h1514);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] want;
      read_word(addrs[k], got);
      want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin n_mis++; $display("FAIL nom_word[%0d]: got %h want %h", addrs[k], got, want); end
    end
  endtask

  task automatic test_short_block();
    int d0, e0;
    logic [15:0] got;
    d0 = done_seen; e0 = err_seen;
    do_req(32'd50);
    n_cmp++; if (bus.sd_sec !== 32'd150) begin n_mis++; $display("FAIL short_sd_sec: got %0d want 150", bus.sd_sec); end
    for (int i = 0; i < 300; i++) send_byte(8'(i + 3), 2, 2);
    pulse_rdone();
    n_cmp++; if (err_seen - e0 !== 1)  begin n_mis++; $display("FAIL short_err_cnt: got %0d want 1", err_seen - e0); end
    n_cmp++; if (done_seen - d0 !== 0) begin n_mis++; $display("FAIL short_done_cnt: got %0d want 0", done_seen - d0); end
    n_cmp++; if (bus.busy !== 1'b0)    begin n_mis++; $display("FAIL short_busy: got %b want 0", bus.busy); end
    read_word(8'd0, got);
    n_cmp++; if (got !== 16'h0403) begin n_mis++; $display("FAIL short_word0: got %h want 0403", got); end
    read_word(8'd149, got);
    n_cmp++; if (got !== 16'h2E2D) begin n_mis++; $display("FAIL short_word149: got %h want 2e2d", got); end
    read_word(8'd150, got);
    n_cmp++; if (got !== 16'h2D2C) begin n_mis++; $display("FAIL short_word150_kept: got %h want 2d2c", got); end
  endtask

  task automatic test_busy_drop();
    int d0, e0;
    logic [15:0] got;
    d0 = done_seen; e0 = err_seen;
    do_req(32'd20);
    for (int i = 0; i < 10; i++) send_byte(8'(i + 7), 2, 2);
    do_req(32'd9);
    n_cmp++; if (bus.sd_sec !== 32'd120) begin n_mis++; $display("FAIL drop_sd_sec: got %0d want 120", bus.sd_sec); end
    n_cmp++; if (bus.busy !== 1'b1)      begin n_mis++; $display("FAIL drop_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.sd_read !== 1'b0)   begin n_mis++; $display("FAIL drop_sd_read: got %b want 0", bus.sd_read); end
    for (int i = 10; i < 512; i++) send_byte(8'(i + 7), 2, 2);
    send_byte(8'hEE, 2, 2);
    send_byte(8'hEE, 2, 2);
    pulse_rdone();
    tick(10);
    n_cmp++; if (done_seen - d0 !== 1) begin n_mis++; $display("FAIL drop_done_cnt: got %0d want 1", done_seen - d0); end
    n_cmp++; if (err_seen - e0 !== 0)  begin n_mis++; $display("FAIL drop_err_cnt: got %0d want 0", err_seen - e0); end
    n_cmp++; if (dbg_state !== 2'd1)   begin n_mis++; $display("FAIL drop_state: got %0d want 1", dbg_state); end
    read_word(8'd0, got);
    n_cmp++; if (got !== 16'h0807) begin n_mis++; $display("FAIL drop_word0_overrun: got %h want 0807", got); end
    read_word(8'd255, got);
    n_cmp++; if (got !== 16'h0605) begin n_mis++; $display("FAIL drop_word255: got %h want 0605", got); end
  endtask

  task automatic test_reset_mid_fill();
    int d0, e0, lat;
    logic [15:0] got;
    do_req(32'd3);
    for (int i = 0; i < 100; i++) send_byte(8'h11, 2, 2);
    rst = 1'b1;
    tick(1);
    n_cmp++; if (bus.sd_read !== 1'b0) begin n_mis++; $display("FAIL rst_fill_sd_read: got %b want 0", bus.sd_read); end
    n_cmp++; if (bus.busy !== 1'b1)    begin n_mis++; $display("FAIL rst_fill_busy: got %b want 1", bus.busy); end
    n_cmp++; if (dbg_state !== 2'd0)   begin n_mis++; $display("FAIL rst_fill_state: got %0d want 0", dbg_state); end
    rst = 1'b0;
    wait_idle(lat);
    n_cmp++; if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL rst_reinit: busy %b after %0d cycles, want 0", bus.busy, lat); end
    do_req(32'd1);
    n_cmp++; if (bus.sd_read !== 1'b1) begin n_mis++; $display("FAIL rst_issue_sd_read: got %b want 1", bus.sd_read); end
    rst = 1'b1;
    tick(1);
    n_cmp++; if (bus.sd_read !== 1'b0) begin n_mis++; $display("FAIL rst_issue_drop: got %b want 0", bus.sd_read); end
    rst = 1'b0;
    wait_idle(lat);
    d0 = done_seen; e0 = err_seen;
    do_req(32'd1);
    n_cmp++; if (bus.sd_sec !== 32'd101) begin n_mis++; $display("FAIL rst_new_sd_sec: got %0d want 101", bus.sd_sec); end
    for (int i = 0; i < 512; i++) send_byte(8'(i) ^ 8'hA5, 2, 2);
    pulse_rdone();
    n_cmp++; if (done_seen - d0 !== 1) begin n_mis++; $display("FAIL rst_new_done_cnt: got %0d want 1", done_seen - d0); end
    n_cmp++; if (err_seen - e0 !== 0)  begin n_mis++; $display("FAIL rst_new_err_cnt: got %0d want 0", err_seen - e0); end
    read_word(8'd3, got);
    n_cmp++; if (got !== 16'hA2A3) begin n_mis++; $display("FAIL rst_new_word3: got %h want a2a3", got); end
  endtask

  task automatic test_init_drop();
    int e0, lat;
    e0 = err_seen;
    do_req(32'd2);
    for (int i = 0; i < 5; i++) send_byte(8'h33, 2, 2);
    bus.sd_init = 1'b0;
    tick(5);
    n_cmp++; if (err_seen - e0 !== 1)  begin n_mis++; $display("FAIL drop_init_err_cnt: got %0d want 1", err_seen - e0); end
    n_cmp++; if (dbg_state !== 2'd0)   begin n_mis++; $display("FAIL drop_init_state: got %0d want 0", dbg_state); end
    n_cmp++; if (bus.busy !== 1'b1)    begin n_mis++; $display("FAIL drop_init_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.sd_read !== 1'b0) begin n_mis++; $display("FAIL drop_init_sd_read: got %b want 0", bus.sd_read); end
    bus.sd_init = 1'b1;
    wait_idle(lat);
    n_cmp++; if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL drop_init_recover: busy %b after %0d cycles, want 0", bus.busy, lat); end
  endtask

`ifdef SECBUF_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    do_req(32'd4);
    lat = 0;
    while (!bus.err && lat < 1100) begin
      tick(1);
      lat++;
    end
    n_cmp++; if (lat !== 1000)         begin n_mis++; $display("FAIL tmo_latency: got %0d cycles want 1000", lat); end
    n_cmp++; if (bus.sd_read !== 1'b0) begin n_mis++; $display("FAIL tmo_sd_read: got %b want 0", bus.sd_read); end
    n_cmp++; if (bus.busy !== 1'b0)    begin n_mis++; $display("FAIL tmo_busy: got %b want 0", bus.busy); end
    send_byte(8'h77, 2, 6);
    n_cmp++; if (dbg_state !== 2'd1)   begin n_mis++; $display("FAIL tmo_late_byte_state: got %0d want 1", dbg_state); end
  endtask
`endif

  initial begin
    bus.req      = 1'b0;
    bus.lba      = 32'd0;
    bus.rd_addr  = 8'd0;
    bus.sd_init  = 1'b0;
    bus.sd_rdone = 1'b0;
    bus.sd_data  = 8'd0;
    bus.sd_valid = 1'b0;
    test_reset();
    test_init_gating();
    test_nominal();
    test_short_block();
    test_busy_drop();
    test_reset_mid_fill();
    test_init_drop();
`ifdef SECBUF_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
